// File: rtl/ex_unit_mc_if.sv
// ex_unit_mc_if: ID/EX -> execute-unit -> EX/MEM signal bundle.
// The master side is the pipeline control (issues ops, consumes results).
// The slave side is the execute unit itself.
interface ex_unit_mc_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic             flush;
   logic [WIDTH-1:0] rd1;
   logic [WIDTH-1:0] rd2;
   logic [WIDTH-1:0] imm;
   logic             alu_src;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic [WIDTH-1:0] fwd_mem;
   logic [WIDTH-1:0] fwd_wb;
   logic [3:0]       op;
   logic             set_flags;
   logic             cbz;
   logic [WIDTH-1:0] result;
   logic             out_valid;
   logic             negative;
   logic             zero;
   logic             overflow;
   logic             carry_out;
   logic             z_eff;

   modport master (
      output in_valid, flush, rd1, rd2, imm, alu_src, fwd_a, fwd_b,
             fwd_mem, fwd_wb, op, set_flags, cbz,
      input  in_ready, result, out_valid, negative, zero, overflow,
             carry_out, z_eff
   );

   modport slave (
      input  in_valid, flush, rd1, rd2, imm, alu_src, fwd_a, fwd_b,
             fwd_mem, fwd_wb, op, set_flags, cbz,
      output in_ready, result, out_valid, negative, zero, overflow,
             carry_out, z_eff
   );
endinterface

// File: rtl/ex_unit_mc.sv
// ex_unit_mc: execute stage with operand forwarding, single-cycle ALU/shifter,
// a WIDTH-cycle iterative shift-add multiplier and the NZVC flag register.
// Result, out_valid, flags and in_ready are all registered.
module ex_unit_mc #(
   parameter  int WIDTH = 64,
   localparam int SHW   = $clog2(WIDTH)
) (
   input logic          clk,
   input logic          reset,
   ex_unit_mc_if.slave  io_bus
);
   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

   localparam logic [3:0] OP_PASSB = 4'b0000;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SUB   = 4'b0011;
   localparam logic [3:0] OP_AND   = 4'b0100;
   localparam logic [3:0] OP_OR    = 4'b0101;
   localparam logic [3:0] OP_XOR   = 4'b0110;
   localparam logic [3:0] OP_MUL   = 4'b1000;
   localparam logic [3:0] OP_LSL   = 4'b1001;
   localparam logic [3:0] OP_LSR   = 4'b1010;

   localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
   localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);
   localparam int               MSB      = WIDTH - 1;

   state_t           r_state;
   logic             r_in_ready;
   logic [WIDTH-1:0] r_result;
   logic             r_out_valid;
   logic             r_n, r_z, r_v, r_c;
   logic             r_cbz;
   logic [SHW-1:0]   r_cnt;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_acc;
   logic             r_mul_sf;
   logic             r_mul_cbz;

   logic [WIDTH-1:0] w_a, w_bf, w_b;
   logic [WIDTH:0]   w_sum, w_diff;
   logic [WIDTH-1:0] w_res;
   logic             w_nz_wr, w_vc_wr, w_v, w_c, w_is_mul;
   logic [WIDTH-1:0] w_acc_next;
   logic             w_accept;

   // Forwarding muxes and immediate select; imm bypasses forwarding entirely.
   always_comb begin
      case (io_bus.fwd_a)
         2'b01:   w_a = io_bus.fwd_mem;
         2'b10:   w_a = io_bus.fwd_wb;
         default: w_a = io_bus.rd1;
      endcase
      case (io_bus.fwd_b)
         2'b01:   w_bf = io_bus.fwd_mem;
         2'b10:   w_bf = io_bus.fwd_wb;
         default: w_bf = io_bus.rd2;
      endcase
      if (io_bus.alu_src) begin
         w_b = io_bus.imm;
      end else begin
         w_b = w_bf;
      end
   end

   // Single-cycle ALU/shifter result and which flag groups the op may update.
   always_comb begin
      w_sum    = {1'b0, w_a} + {1'b0, w_b};
      w_diff   = {1'b0, w_a} + {1'b0, ~w_b} + {{WIDTH{1'b0}}, 1'b1};
      w_res    = ZERO;
      w_nz_wr  = 1'b0;
      w_vc_wr  = 1'b0;
      w_v      = 1'b0;
      w_c      = 1'b0;
      w_is_mul = 1'b0;
      case (io_bus.op)
         OP_PASSB: begin w_res = w_b;         w_nz_wr = 1'b1; w_vc_wr = 1'b1; end
         OP_AND:   begin w_res = w_a & w_b;   w_nz_wr = 1'b1; w_vc_wr = 1'b1; end
         OP_OR:    begin w_res = w_a | w_b;   w_nz_wr = 1'b1; w_vc_wr = 1'b1; end
         OP_XOR:   begin w_res = w_a ^ w_b;   w_nz_wr = 1'b1; w_vc_wr = 1'b1; end
         OP_ADD: begin
            w_res   = w_sum[WIDTH-1:0];
            w_nz_wr = 1'b1;
            w_vc_wr = 1'b1;
            w_c     = w_sum[WIDTH];
            w_v     = (w_a[MSB] == w_b[MSB]) && (w_sum[MSB] != w_a[MSB]);
         end
         OP_SUB: begin
            w_res   = w_diff[WIDTH-1:0];
            w_nz_wr = 1'b1;
            w_vc_wr = 1'b1;
            w_c     = w_diff[WIDTH];
            w_v     = (w_a[MSB] != w_b[MSB]) && (w_diff[MSB] != w_a[MSB]);
         end
         OP_LSL:   begin w_res = w_a << w_b[SHW-1:0]; w_nz_wr = 1'b1; end
         OP_LSR:   begin w_res = w_a >> w_b[SHW-1:0]; w_nz_wr = 1'b1; end
         OP_MUL:   begin w_is_mul = 1'b1; end
         default:  begin w_res = ZERO; end
      endcase
   end

   // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
   always_comb begin
      if (r_mplier[0]) begin
         w_acc_next = r_acc + r_mcand;
      end else begin
         w_acc_next = r_acc;
      end
      w_accept = io_bus.in_valid & r_in_ready & ~io_bus.flush;
   end

   // Control FSM with all registered outputs; flush outranks accept and completion.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b1;
         r_result    <= ZERO;
         r_out_valid <= 1'b0;
         r_n         <= 1'b0;
         r_z         <= 1'b0;
         r_v         <= 1'b0;
         r_c         <= 1'b0;
         r_cbz       <= 1'b0;
         r_cnt       <= {SHW{1'b0}};
         r_mcand     <= ZERO;
         r_mplier    <= ZERO;
         r_acc       <= ZERO;
         r_mul_sf    <= 1'b0;
         r_mul_cbz   <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept && w_is_mul) begin
                  r_state    <= ST_MUL;
                  r_in_ready <= 1'b0;
                  r_mcand    <= w_a;
                  r_mplier   <= w_b;
                  r_acc      <= ZERO;
                  r_cnt      <= {SHW{1'b0}};
                  r_mul_sf   <= io_bus.set_flags;
                  r_mul_cbz  <= io_bus.cbz;
               end else if (w_accept) begin
                  r_result    <= w_res;
                  r_out_valid <= 1'b1;
                  r_cbz       <= io_bus.cbz;
                  if (io_bus.set_flags && w_nz_wr) begin
                     r_n <= w_res[MSB];
                     r_z <= (w_res == ZERO);
                  end
                  if (io_bus.set_flags && w_vc_wr) begin
                     r_v <= w_v;
                     r_c <= w_c;
                  end
               end else begin
                  r_in_ready <= 1'b1;
               end
            end
            ST_MUL: begin
               if (io_bus.flush) begin
                  r_state    <= ST_IDLE;
                  r_in_ready <= 1'b1;
                  r_cnt      <= {SHW{1'b0}};
               end else if (r_cnt == CNT_LAST) begin
                  r_state     <= ST_IDLE;
                  r_in_ready  <= 1'b1;
                  r_cnt       <= {SHW{1'b0}};
                  r_result    <= w_acc_next;
                  r_out_valid <= 1'b1;
                  r_cbz       <= r_mul_cbz;
                  if (r_mul_sf) begin
                     r_n <= w_acc_next[MSB];
                     r_z <= (w_acc_next == ZERO);
                  end
               end else begin
                  r_acc    <= w_acc_next;
                  r_mcand  <= r_mcand << 1;
                  r_mplier <= r_mplier >> 1;
                  r_cnt    <= r_cnt + {{(SHW-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_in_ready <= 1'b1;
            end
         endcase
      end
   end

   assign io_bus.in_ready  = r_in_ready;
   assign io_bus.result    = r_result;
   assign io_bus.out_valid = r_out_valid;
   assign io_bus.negative  = r_n;
   assign io_bus.zero      = r_z;
   assign io_bus.overflow  = r_v;
   assign io_bus.carry_out = r_c;
   assign io_bus.z_eff     = r_cbz ? (r_result == ZERO) : r_z;
endmodule

// File: tb/tb_ex_unit_mc.sv
// tb_ex_unit_mc: directed self-checking bench for ex_unit_mc (WIDTH = 64).
module tb_ex_unit_mc;
   localparam int W = 64;
   localparam logic [3:0] OP_PASSB = 4'b0000;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SUB   = 4'b0011;
   localparam logic [3:0] OP_AND   = 4'b0100;
   localparam logic [3:0] OP_XOR   = 4'b0110;
   localparam logic [3:0] OP_RSVD  = 4'b0111;
   localparam logic [3:0] OP_MUL   = 4'b1000;
   localparam logic [3:0] OP_LSL   = 4'b1001;
   localparam logic [3:0] OP_LSR   = 4'b1010;

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   low_cnt;
   int   pulses;

   ex_unit_mc_if #(.WIDTH(W)) bus ();

   ex_unit_mc #(.WIDTH(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] imm, input logic src, input logic [1:0] fa,
                        input logic [1:0] fb, input logic sf, input logic cz);
      bus.in_valid  = 1'b1;
      bus.op        = op;
      bus.rd1       = a;
      bus.rd2       = b;
      bus.imm       = imm;
      bus.alu_src   = src;
      bus.fwd_a     = fa;
      bus.fwd_b     = fb;
      bus.set_flags = sf;
      bus.cbz       = cz;
   endtask

   function automatic logic [63:0] nzvc();
      return {60'd0, bus.negative, bus.zero, bus.overflow, bus.carry_out};
   endfunction

   initial begin
      reset = 1'b0;
      bus.in_valid = 1'b0; bus.flush = 1'b0; bus.op = 4'd0;
      bus.rd1 = 64'd0; bus.rd2 = 64'd0; bus.imm = 64'd0; bus.alu_src = 1'b0;
      bus.fwd_a = 2'd0; bus.fwd_b = 2'd0; bus.fwd_mem = 64'd0; bus.fwd_wb = 64'd0;
      bus.set_flags = 1'b0; bus.cbz = 1'b0;
      tick(); tick();
      chk("rst_result", bus.result, 64'd0);
      chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst_flags", nzvc(), 64'h0);
      reset = 1'b1;
      tick();
      chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

      // add without flag update
      drive(OP_ADD, 64'h2AA, 64'h155, 64'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
      tick(); bus.in_valid = 1'b0;
      chk("add_result", bus.result, 64'h3FF);
      chk("add_out_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("add_flags", nzvc(), 64'h0);
      tick();
      chk("add_out_valid_drop", {63'd0, bus.out_valid}, 64'd0);

      // sub to zero sets Z and C; and without set_flags keeps them
      drive(OP_SUB, 64'h5, 64'h5, 64'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
      tick(); bus.in_valid = 1'b0;
      chk("sub_result", bus.result, 64'd0);
      chk("sub_flags", nzvc(), 64'h5);
      chk("sub_z_eff", {63'd0, bus.z_eff}, 64'd1);
      drive(OP_AND, 64'hFF, 64'h0F, 64'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
      tick(); bus.in_valid = 1'b0;
      chk("and_result", bus.result, 64'h0F);
      chk("and_flags_kept", nzvc(), 64'h5);

      // lsl by imm 63: N set, Z cleared, V/C kept
      drive(OP_LSL, 64'h1, 64'd0, 64'd63, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0);
      tick(); bus.in_valid = 1'b0;
      chk("lsl_result", bus.result, 64'h8000_0000_0000_0000);
      chk("lsl_flags", nzvc(), 64'h9);

      // back-to-back: lsr by 64 (amount 0) then xor
      drive(OP_LSR, 64'h80, 64'd0, 64'd64, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
      tick();
      chk("lsr0_result", bus.result, 64'h80);
      chk("lsr0_out_valid", {63'd0, bus.out_valid}, 64'd1);
      drive(OP_XOR, 64'hF0, 64'h0F, 64'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
      tick(); bus.in_valid = 1'b0;
      chk("xor_result", bus.result, 64'hFF);
      chk("xor_out_valid", {63'd0, bus.out_valid}, 64'd1);
      tick();
      chk("b2b_out_valid_drop", {63'd0, bus.out_valid}, 64'd0);

      // forwarded add overflowing into the sign bit
      bus.fwd_mem = 64'h7FFF_FFFF_FFFF_FFFF;
      bus.fwd_wb  = 64'h1;
      drive(OP_ADD, 64'h1234, 64'h99, 64'd0, 1'b0, 2'b01, 2'b10, 1'b1, 1'b0);
      tick(); bus.in_valid = 1'b0;
      chk("fwd_add_result", bus.result, 64'h8000_0000_0000_0000);
      chk("fwd_add_flags", nzvc(), 64'hA);

      // reserved op: result 0, pulse, flags untouched
      drive(OP_RSVD, 64'h3, 64'h4, 64'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
      tick(); bus.in_valid = 1'b0;
      chk("rsvd_result", bus.result, 64'd0);
      chk("rsvd_out_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("rsvd_flags", nzvc(), 64'hA);

      // passB with alu_src=1: imm wins over forwarded B
      bus.fwd_wb = 64'hDEAD;
      drive(OP_PASSB, 64'd0, 64'h77, 64'h55, 1'b1, 2'b00, 2'b10, 1'b1, 1'b0);
      tick(); bus.in_valid = 1'b0;
      chk("passb_imm_result", bus.result, 64'h55);
      chk("passb_flags", nzvc(), 64'h0);

      // sub without borrow sets C ahead of the multiply
      drive(OP_SUB, 64'h5, 64'h3, 64'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
      tick(); bus.in_valid = 1'b0;
      chk("sub2_result", bus.result, 64'h2);
      chk("sub2_flags", nzvc(), 64'h1);

      // multiply with an add held on in_valid throughout the busy window
      drive(OP_MUL, 64'hFFFF_FFFF, 64'h3, 64'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
      tick();
      chk("mul_in_ready_e0", {63'd0, bus.in_ready}, 64'd0);
      drive(OP_ADD, 64'h1, 64'h1, 64'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
      low_cnt = 0;
      pulses  = 0;
      while (bus.in_ready === 1'b0 && low_cnt < 200) begin
         low_cnt++;
         if (bus.out_valid === 1'b1) pulses++;
         tick();
      end
      bus.in_valid = 1'b0;
      chk("mul_busy_cycles", 64'(low_cnt), 64'd64);
      chk("mul_busy_pulses", 64'(pulses), 64'd0);
      chk("mul_result", bus.result, 64'h2_FFFF_FFFD);
      chk("mul_out_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("mul_flags", nzvc(), 64'h1);
      tick();
      chk("mul_out_valid_drop", {63'd0, bus.out_valid}, 64'd0);

      // flush in IDLE blocks the accept
      drive(OP_ADD, 64'h1, 64'h1, 64'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
      bus.flush = 1'b1;
      tick(); bus.in_valid = 1'b0; bus.flush = 1'b0;
      chk("flush_idle_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("flush_idle_result", bus.result, 64'h2_FFFF_FFFD);

      // flush at E10 of a multiply
      drive(OP_MUL, 64'h5, 64'h7, 64'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
      tick(); bus.in_valid = 1'b0;
      repeat (9) tick();
      bus.flush = 1'b1;
      tick(); bus.flush = 1'b0;
      chk("flush_mul_in_ready", {63'd0, bus.in_ready}, 64'd1);
      chk("flush_mul_out_valid", {63'd0, bus.out_valid}, 64'd0);
      pulses = 0;
      for (int i = 0; i < 70; i++) begin
         tick();
         if (bus.out_valid === 1'b1) pulses++;
      end
      chk("flush_mul_pulses", 64'(pulses), 64'd0);
      chk("flush_mul_result", bus.result, 64'h2_FFFF_FFFD);
      chk("flush_mul_flags", nzvc(), 64'h1);

      // reset asserted just before E5 of a multiply
      drive(OP_MUL, 64'h5, 64'h7, 64'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
      tick(); bus.in_valid = 1'b0;
      repeat (4) tick();
      #2 reset = 1'b0;
      #1;
      chk("rstmul_result", bus.result, 64'd0);
      chk("rstmul_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rstmul_flags", nzvc(), 64'h0);
      chk("rstmul_in_ready", {63'd0, bus.in_ready}, 64'd1);
      tick();
      reset = 1'b1;
      pulses = 0;
      for (int i = 0; i < 70; i++) begin
         tick();
         if (bus.out_valid === 1'b1) pulses++;
      end
      chk("rstmul_pulses", 64'(pulses), 64'd0);
      chk("rstmul_in_ready_after", {63'd0, bus.in_ready}, 64'd1);

      // CBZ bypass: z_eff tracks own result, then falls back to the Z flag
      drive(OP_SUB, 64'h9, 64'h9, 64'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
      tick(); bus.in_valid = 1'b0;
      chk("cbz_result", bus.result, 64'd0);
      chk("cbz_zero_flag", {63'd0, bus.zero}, 64'd0);
      chk("cbz_z_eff", {63'd0, bus.z_eff}, 64'd1);
      drive(OP_SUB, 64'h9, 64'h9, 64'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
      tick(); bus.in_valid = 1'b0;
      chk("nocbz_result", bus.result, 64'd0);
      chk("nocbz_z_eff", {63'd0, bus.z_eff}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
